// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package bcd_timer_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Digit 1 is the tens-of-seconds digit in mm:ss mode.
    function automatic logic [DIGIT_W-1:0] digit_max(input int index, input logic mm_ss);
        return (index == 1 && mm_ss) ? 4'd5 : 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with saturating load and wrap-to-MAX on borrow.
module bcd_digit_down
    import bcd_timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               dec,
    output logic [DIGIT_W-1:0] digit,
    output logic               is_zero,
    output logic               clamped_o
);

    logic over;

    assign over    = (load_val > MAX);
    assign is_zero = (digit == '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            digit     <= '0;
            clamped_o <= 1'b0;
        end else if (load) begin
            digit     <= over ? MAX : load_val;
            clamped_o <= over;
        end else begin
            clamped_o <= 1'b0;
            if (dec) begin
                digit <= is_zero ? MAX : digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with run/pause control, halting at zero
// with a one-cycle done pulse.
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MM_SS      = 1
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          tick,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] data,
    input  logic                          start,
    input  logic                          pause,
    output logic [DIGIT_W*NUM_DIGITS-1:0] out,
    output logic                          zero,
    output logic                          running,
    output logic                          done,
    output logic                          clamped
);

    state_t                state;
    logic [NUM_DIGITS-1:0] is_zero;
    logic [NUM_DIGITS-1:0] dec;
    logic [NUM_DIGITS-1:0] clamp_bits;
    logic [NUM_DIGITS:0]   lower_zero;
    logic                  run_tick;
    logic                  upper_zero;
    logic                  at_one;

    // load and pause both outrank tick, so either one suppresses the decrement.
    assign run_tick      = (state == RUN) && tick && !load && !pause;
    assign lower_zero[0] = 1'b1;

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            assign lower_zero[i+1] = lower_zero[i] & is_zero[i];
            assign dec[i]          = run_tick & lower_zero[i];

            bcd_digit_down #(
                .MAX(digit_max(i, MM_SS != 0))
            ) u_digit (
                .clk      (clk),
                .clr      (clr),
                .load     (load),
                .load_val (data[DIGIT_W*i +: DIGIT_W]),
                .dec      (dec[i]),
                .digit    (out[DIGIT_W*i +: DIGIT_W]),
                .is_zero  (is_zero[i]),
                .clamped_o(clamp_bits[i])
            );
        end
    endgenerate

    always_comb begin
        upper_zero = 1'b1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            upper_zero = upper_zero & is_zero[i];
        end
    end

    // A decrement from exactly 1 is the only way the count reaches zero.
    assign at_one  = (out[DIGIT_W-1:0] == 4'd1) && upper_zero;
    assign zero    = lower_zero[NUM_DIGITS];
    assign running = (state == RUN);
    assign clamped = |clamp_bits;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!pause && start && !zero) state <= RUN;
                    end
                    RUN: begin
                        if (pause) begin
                            state <= PAUSE;
                        end else if (run_tick && at_one) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (!pause && start) state <= RUN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: an mm:ss instance and a plain-decimal
// instance share every input so each stimulus is checked against both.
module tb_bcd_countdown_timer;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         clr, tick, load, start, pause;
    logic [W-1:0] data;

    logic [W-1:0] out_a, out_b;
    logic         zero_a, running_a, done_a, clamped_a;
    logic         zero_b, running_b, done_b, clamped_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.NUM_DIGITS(N), .MM_SS(1)) u_dut_a (
        .clk(clk), .clr(clr), .tick(tick), .load(load), .data(data),
        .start(start), .pause(pause), .out(out_a), .zero(zero_a),
        .running(running_a), .done(done_a), .clamped(clamped_a)
    );

    bcd_countdown_timer #(.NUM_DIGITS(N), .MM_SS(0)) u_dut_b (
        .clk(clk), .clr(clr), .tick(tick), .load(load), .data(data),
        .start(start), .pause(pause), .out(out_b), .zero(zero_b),
        .running(running_b), .done(done_b), .clamped(clamped_b)
    );

    // Drive one cycle of inputs; outputs are sampled 1ns after the edge.
    task automatic cycle(input logic c, input logic l, input logic [W-1:0] d,
                         input logic s, input logic p, input logic t);
        clr = c; load = l; data = d; start = s; pause = p; tick = t;
        @(posedge clk);
        #1;
        clr = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, data, 0, 0, 0);
    endtask

    function automatic int mmss_to_s(input logic [W-1:0] v);
        return int'(v[15:12]) * 600 + int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [W-1:0] s_to_mmss(input int s);
        int m;
        m = s / 60;
        return {4'(m / 10), 4'(m % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic int dec_to_i(input logic [W-1:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [W-1:0] i_to_dec(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic test_reset;
        cycle(1, 0, '0, 0, 0, 0);
        n_cmp++; if (out_a !== 16'h0000) begin n_err++; $display("FAIL reset_out got=%h exp=0000", out_a); end
        n_cmp++; if ({zero_a, running_a, done_a, clamped_a} !== 4'b1000) begin
            n_err++; $display("FAIL reset_flags got=%b exp=1000", {zero_a, running_a, done_a, clamped_a}); end
        cycle(0, 1, 16'h0042, 0, 0, 0);
        cycle(0, 0, 16'h0042, 1, 0, 0);
        n_cmp++; if (running_a !== 1'b1) begin n_err++; $display("FAIL reset_pre_run got=%b exp=1", running_a); end
        cycle(1, 0, 16'h0042, 0, 0, 1);
        n_cmp++; if (out_a !== 16'h0000) begin n_err++; $display("FAIL reset_mid_out got=%h exp=0000", out_a); end
        n_cmp++; if ({zero_a, running_a, done_a} !== 3'b100) begin
            n_err++; $display("FAIL reset_mid_flags got=%b exp=100", {zero_a, running_a, done_a}); end
        cycle(0, 0, '0, 0, 0, 1);
        cycle(0, 0, '0, 0, 0, 1);
        n_cmp++; if (out_a !== 16'h0000) begin n_err++; $display("FAIL reset_ticks got=%h exp=0000", out_a); end
    endtask

    task automatic test_borrow;
        cycle(0, 1, 16'h0100, 0, 0, 0);
        cycle(0, 0, 16'h0100, 1, 0, 0);
        exp_q.push_back(16'h0059);
        exp_q.push_back(16'h0099);
        cycle(0, 0, 16'h0100, 0, 0, 1);
        e = exp_q.pop_front();
        n_cmp++; if (out_a !== e) begin n_err++; $display("FAIL borrow_mmss got=%h exp=%h", out_a, e); end
        e = exp_q.pop_front();
        n_cmp++; if (out_b !== e) begin n_err++; $display("FAIL borrow_dec got=%h exp=%h", out_b, e); end
    endtask

    task automatic test_terminal;
        cycle(0, 1, 16'h0002, 0, 0, 0);
        cycle(0, 0, 16'h0002, 1, 0, 0);
        cycle(0, 0, 16'h0002, 0, 0, 1);
        exp_q.push_back(16'h0000);
        cycle(0, 0, 16'h0002, 0, 0, 1);
        e = exp_q.pop_front();
        n_cmp++; if (out_a !== e) begin n_err++; $display("FAIL term_out got=%h exp=%h", out_a, e); end
        n_cmp++; if ({zero_a, running_a, done_a} !== 3'b101) begin
            n_err++; $display("FAIL term_flags got=%b exp=101", {zero_a, running_a, done_a}); end
        idle(1);
        n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL term_done_clear got=%b exp=0", done_a); end
        exp_q.push_back(16'h0000);
        cycle(0, 0, 16'h0002, 0, 0, 1);
        e = exp_q.pop_front();
        n_cmp++; if (out_a !== e || done_a !== 1'b0) begin
            n_err++; $display("FAIL term_halt got=%h/%b exp=%h/0", out_a, done_a, e); end
    endtask

    task automatic test_pause;
        cycle(0, 1, 16'h0030, 0, 0, 0);
        cycle(0, 0, 16'h0030, 1, 0, 0);
        exp_q.push_back(16'h0029);
        cycle(0, 0, 16'h0030, 0, 0, 1);
        e = exp_q.pop_front();
        n_cmp++; if (out_a !== e) begin n_err++; $display("FAIL pause_first got=%h exp=%h", out_a, e); end
        cycle(0, 0, 16'h0030, 1, 1, 0);
        n_cmp++; if (running_a !== 1'b0) begin n_err++; $display("FAIL pause_wins got=%b exp=0", running_a); end
        exp_q.push_back(16'h0029);
        cycle(0, 0, 16'h0030, 0, 0, 1);
        e = exp_q.pop_front();
        n_cmp++; if (out_a !== e) begin n_err++; $display("FAIL pause_tick got=%h exp=%h", out_a, e); end
        cycle(0, 0, 16'h0030, 1, 0, 0);
        n_cmp++; if (running_a !== 1'b1) begin n_err++; $display("FAIL pause_resume got=%b exp=1", running_a); end
        exp_q.push_back(16'h0028);
        cycle(0, 0, 16'h0030, 0, 0, 1);
        e = exp_q.pop_front();
        n_cmp++; if (out_a !== e) begin n_err++; $display("FAIL pause_resumed_tick got=%h exp=%h", out_a, e); end
        cycle(0, 0, 16'h0030, 0, 1, 0);
        exp_q.push_back(16'h0028);
        cycle(0, 0, 16'h0030, 1, 0, 1);
        e = exp_q.pop_front();
        n_cmp++; if (out_a !== e || running_a !== 1'b1) begin
            n_err++; $display("FAIL pause_start_tick got=%h/%b exp=%h/1", out_a, running_a, e); end
        exp_q.push_back(16'h0027);
        cycle(0, 0, 16'h0030, 0, 0, 1);
        e = exp_q.pop_front();
        n_cmp++; if (out_a !== e) begin n_err++; $display("FAIL pause_after got=%h exp=%h", out_a, e); end
    endtask

    task automatic test_clamp;
        exp_q.push_back(16'h0959);
        exp_q.push_back(16'h0979);
        cycle(0, 1, 16'h0A7C, 0, 0, 0);
        e = exp_q.pop_front();
        n_cmp++; if (out_a !== e || clamped_a !== 1'b1) begin
            n_err++; $display("FAIL clamp_mmss got=%h/%b exp=%h/1", out_a, clamped_a, e); end
        e = exp_q.pop_front();
        n_cmp++; if (out_b !== e || clamped_b !== 1'b1) begin
            n_err++; $display("FAIL clamp_dec got=%h/%b exp=%h/1", out_b, clamped_b, e); end
        n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL clamp_no_done got=%b exp=0", done_a); end
        idle(1);
        n_cmp++; if (clamped_a !== 1'b0) begin n_err++; $display("FAIL clamp_pulse got=%b exp=0", clamped_a); end
        cycle(0, 1, 16'h0059, 0, 0, 0);
        n_cmp++; if (clamped_a !== 1'b0) begin n_err++; $display("FAIL clamp_legal got=%b exp=0", clamped_a); end
    endtask

    task automatic test_start_zero_load;
        cycle(0, 1, 16'h0000, 0, 0, 0);
        cycle(0, 0, 16'h0000, 1, 0, 0);
        n_cmp++; if (running_a !== 1'b0 || out_a !== 16'h0000) begin
            n_err++; $display("FAIL start_zero got=%h/%b exp=0000/0", out_a, running_a); end
        cycle(0, 1, 16'h0015, 0, 0, 0);
        cycle(0, 0, 16'h0015, 1, 0, 0);
        exp_q.push_back(16'h0300);
        cycle(0, 1, 16'h0300, 0, 0, 1);
        e = exp_q.pop_front();
        n_cmp++; if (out_a !== e) begin n_err++; $display("FAIL load_abort_out got=%h exp=%h", out_a, e); end
        n_cmp++; if ({running_a, done_a} !== 2'b00) begin
            n_err++; $display("FAIL load_abort_flags got=%b exp=00", {running_a, done_a}); end
        cycle(0, 0, 16'h0300, 0, 0, 1);
        n_cmp++; if (out_a !== 16'h0300) begin n_err++; $display("FAIL load_abort_idle got=%h exp=0300", out_a); end
    endtask

    task automatic test_back_to_back;
        for (int it = 0; it < 6; it++) begin
            logic [W-1:0] v;
            int k, sa, sb;
            v = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            k  = $urandom_range(1, 40);
            sa = mmss_to_s(v) - k;
            sb = dec_to_i(v) - k;
            if (sa < 0) sa = 0;
            if (sb < 0) sb = 0;
            exp_q.push_back(s_to_mmss(sa));
            exp_q.push_back(i_to_dec(sb));
            cycle(0, 1, v, 0, 0, 0);
            cycle(0, 0, v, 1, 0, 0);
            for (int t = 0; t < k; t++) begin
                cycle(0, 0, v, 0, 0, 1);
                idle($urandom_range(0, 2));
            end
            e = exp_q.pop_front();
            n_cmp++; if (out_a !== e) begin n_err++; $display("FAIL rand_mmss v=%h k=%0d got=%h exp=%h", v, k, out_a, e); end
            n_cmp++; if (running_a !== (sa != 0)) begin
                n_err++; $display("FAIL rand_running v=%h k=%0d got=%b exp=%b", v, k, running_a, sa != 0); end
            e = exp_q.pop_front();
            n_cmp++; if (out_b !== e) begin n_err++; $display("FAIL rand_dec v=%h k=%0d got=%h exp=%h", v, k, out_b, e); end
        end
    endtask

    initial begin
        clr = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; data = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_borrow();
        test_terminal();
        test_pause();
        test_clamp();
        test_start_zero_load();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
